// File: rtl/flick_input_conditioner.sv
// Purpose: synchronise and debounce a raw push-button and emit one stretched flick pulse per accepted press.
// Latency: flick rises SYNC_STAGES+DEBOUNCE_CYCLES edges after btn_raw is first sampled high; all outputs registered.
// Backpressure: none; flick is a fire-and-forget pulse held PULSE_LEN cycles so the consumer can catch it.
module flick_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 3,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  output logic             flick,
  output logic             btn_level,
  output logic [CNT_W-1:0] press_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCW-1:0] PULSE_MAX = PCW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  state_t                 state_q, state_d;
  logic [DBW-1:0]         db_cnt_q, db_cnt_d;
  logic [PCW-1:0]         pulse_cnt_q;
  logic                   accept;
  logic                   release_done;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: btn_raw enters at bit 0, btn_sync leaves from the top bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  // Debounce state and stability counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Next-state logic; accept/release_done mark the edges where the debounced level changes.
  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    accept       = 1'b0;
    release_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_MAX) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        // A short low blip returns to PRESSED without re-triggering a pulse.
        if (btn_sync) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_MAX) begin
          state_d      = IDLE;
          release_done = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Debounced level and press counter update on acceptance / completed release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level   <= 1'b0;
      press_count <= '0;
    end else begin
      if (accept) begin
        btn_level   <= 1'b1;
        press_count <= press_count + 1'b1;
      end else if (release_done) begin
        btn_level <= 1'b0;
      end
    end
  end

  // Pulse stretcher: reload on acceptance, count down, drop flick once the count is exhausted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flick       <= 1'b0;
      pulse_cnt_q <= '0;
    end else if (accept) begin
      flick       <= 1'b1;
      pulse_cnt_q <= PULSE_MAX;
    end else if (pulse_cnt_q != '0) begin
      pulse_cnt_q <= pulse_cnt_q - 1'b1;
    end else if (flick) begin
      flick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flick_input_conditioner.sv
// Directed bench for flick_input_conditioner at default parameters.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Expected values are hand-derived edge counts from the first edge sampling btn_raw.
module tb_flick_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_raw = 1'b0;
  logic       flick;
  logic       btn_level;
  logic [7:0] press_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_cnt  = 8'd0;

  flick_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .PULSE_LEN      (3),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .flick      (flick),
    .btn_level  (btn_level),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full press (12 edges high) and release (10 edges low), counting flick cycles.
  task automatic press_release(input int idx);
    int fc;
    fc = 0;
    btn_raw = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (flick) fc++;
    end
    exp_cnt = exp_cnt + 8'd1;
    check($sformatf("wrap_cnt[%0d]", idx), 32'(press_count), 32'(exp_cnt));
    btn_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (flick) fc++;
    end
    check($sformatf("wrap_flick_len[%0d]", idx), 32'(fc), 32'd3);
    check($sformatf("wrap_level_low[%0d]", idx), 32'(btn_level), 32'd0);
  endtask

  // Clean press with btn_raw high from the next edge (E0); e indexes edge E(e).
  task automatic clean_press(input string name, input logic [7:0] cnt_after);
    btn_raw = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      check($sformatf("%s_flick_E%0d", name, e), 32'(flick), 32'((e >= 6 && e <= 8) ? 1 : 0));
      check($sformatf("%s_level_E%0d", name, e), 32'(btn_level), 32'((e >= 6) ? 1 : 0));
      check($sformatf("%s_cnt_E%0d", name, e), 32'(press_count),
            32'((e >= 6) ? cnt_after : cnt_after - 8'd1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_flick", 32'(flick), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_cnt", 32'(press_count), 32'd0);
    rst = 1'b0;
    tick();

    // Press bounce: high 3 cycles, then low; nothing may change
    btn_raw = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      check($sformatf("bounce_flick_hi%0d", e), 32'(flick), 32'd0);
    end
    btn_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check($sformatf("bounce_flick_E%0d", e), 32'(flick), 32'd0);
      check($sformatf("bounce_level_E%0d", e), 32'(btn_level), 32'd0);
      check($sformatf("bounce_cnt_E%0d", e), 32'(press_count), 32'd0);
    end

    // Clean press held 20 cycles
    clean_press("press1", 8'd1);

    // Release glitch: low for 2 samples then high again
    btn_raw = 1'b0;
    tick();
    tick();
    btn_raw = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      check($sformatf("glitch_level_E%0d", e), 32'(btn_level), 32'd1);
      check($sformatf("glitch_flick_E%0d", e), 32'(flick), 32'd0);
      check($sformatf("glitch_cnt_E%0d", e), 32'(press_count), 32'd1);
    end

    // Full release: level falls on the 6th edge sampling low (index 6)
    btn_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check($sformatf("release_level_E%0d", e), 32'(btn_level), 32'((e < 6) ? 1 : 0));
      check($sformatf("release_flick_E%0d", e), 32'(flick), 32'd0);
    end

    // Second clean press
    clean_press("press2", 8'd2);
    btn_raw = 1'b0;
    for (int e = 0; e < 10; e++) tick();
    check("press2_released", 32'(btn_level), 32'd0);

    // Counter wrap: presses 3..256, the 256th wraps 255 -> 0
    exp_cnt = 8'd2;
    for (int i = 3; i <= 256; i++) begin
      if (i == 256) check("wrap_pre_255", 32'(press_count), 32'd255);
      press_release(i);
    end
    check("wrap_to_zero", 32'(press_count), 32'd0);

    // Reset mid-pulse: assert during the second flick cycle (after E7)
    btn_raw = 1'b1;
    for (int e = 0; e < 8; e++) tick();
    check("midpulse_flick_before", 32'(flick), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midpulse_rst_flick", 32'(flick), 32'd0);
    check("midpulse_rst_level", 32'(btn_level), 32'd0);
    check("midpulse_rst_cnt", 32'(press_count), 32'd0);
    tick();
    tick();
    check("midpulse_held_flick", 32'(flick), 32'd0);
    rst = 1'b0;
    clean_press("after_rst", 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
